// File: rtl/pcie_tlp_pkg.sv
// Completion TLP field positions, status encodings and serializer FSM states.
package pcie_tlp_pkg;

   localparam int FMT_HI          = 31;
   localparam int FMT_DATA_BIT    = 30;
   localparam int CPL_STATUS_HI   = 47;
   localparam int CPL_STATUS_LO   = 45;
   localparam int COMPLETER_ID_HI = 63;
   localparam int COMPLETER_ID_LO = 48;

   localparam logic [2:0]  CPL_SC      = 3'b000;
   localparam logic [2:0]  CPL_UR      = 3'b001;
   localparam logic [2:0]  CPL_DEFAULT = 3'b111;
   localparam logic [15:0] DEFAULT_CID = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND0 = 2'd1,
      SEND1 = 2'd2
   } ser_state_t;

   // Fmt is two bits here; its low bit is the data-present flag.
   function automatic logic tlp_has_data(input logic [95:0] hdr);
      return (hdr[FMT_HI:FMT_DATA_BIT] & 2'b01) != 2'b00;
   endfunction

   // Upstream leaves a default completer ID and default status; fill them in.
   function automatic logic [95:0] finalize_hdr(input logic [95:0] hdr,
                                                input logic [15:0] cid);
      logic [95:0] f;
      f = hdr;
      if (hdr[COMPLETER_ID_HI:COMPLETER_ID_LO] == DEFAULT_CID)
         f[COMPLETER_ID_HI:COMPLETER_ID_LO] = cid;
      case (hdr[CPL_STATUS_HI:CPL_STATUS_LO])
         CPL_DEFAULT: f[CPL_STATUS_HI:CPL_STATUS_LO] = CPL_SC;
         CPL_SC,
         CPL_UR:      f[CPL_STATUS_HI:CPL_STATUS_LO] = hdr[CPL_STATUS_HI:CPL_STATUS_LO];
         default:     f[CPL_STATUS_HI:CPL_STATUS_LO] = hdr[CPL_STATUS_HI:CPL_STATUS_LO];
      endcase
      return f;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers; level/full/empty derive from the pointers only.
module sync_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int              AW       = $clog2(DEPTH);
   localparam logic [AW:0]     FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign level   = wr_ptr - rd_ptr;
   assign full    = (level == FULL_LVL);
   assign empty   = (wr_ptr == rd_ptr);
   assign rd_data = mem[rd_ptr[AW-1:0]];
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;

   // Pointer update; the extra MSB distinguishes full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage array, no reset needed since empty gates every read.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/cpl_tlp_serializer.sv
// Buffers finished completion headers and emits each TLP as two 64-bit beats.
//
// state | meaning
// IDLE  | no beat presented; pop next entry when FIFO non-empty
// SEND0 | beat0 {DW1', DW0} presented with sop
// SEND1 | beat1 {payload|0, DW2} presented with eop; chains to next TLP without bubble
module cpl_tlp_serializer
   import pcie_tlp_pkg::*;
#(
   parameter int          DATA_WIDTH   = 64,
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [15:0] COMPLETER_ID = 16'h0000
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [95:0]                     in_header,
   input  logic [31:0]                     in_payload,
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic [DATA_WIDTH-1:0]           out_data,
   output logic [1:0]                      out_keep,
   output logic                            out_sop,
   output logic                            out_eop,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic [15:0]                     cpl_count
);

   if (DATA_WIDTH != 64) begin : g_bad_data_width
      $error("cpl_tlp_serializer: DATA_WIDTH must be 64");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
      $error("cpl_tlp_serializer: FIFO_DEPTH must be a power of two >= 2");
   end

   ser_state_t   state;
   logic         fifo_full;
   logic         fifo_empty;
   logic         fifo_wr;
   logic         fifo_rd;
   logic [127:0] fifo_rd_data;
   logic [95:0]  hdr_fin;
   logic         pop_has_data;

   logic [31:0]  hold_dw2;
   logic [31:0]  hold_payload;
   logic         hold_has_data;

   assign in_ready     = !fifo_full;
   assign fifo_wr      = in_valid && !fifo_full;
   assign hdr_fin      = finalize_hdr(fifo_rd_data[95:0], COMPLETER_ID);
   assign pop_has_data = tlp_has_data(fifo_rd_data[95:0]);

   // Pop whenever the output stage is free or about to free up.
   always_comb begin
      fifo_rd = 1'b0;
      if (!fifo_empty) begin
         if (state == IDLE)
            fifo_rd = 1'b1;
         else if ((state == SEND1) && out_ready)
            fifo_rd = 1'b1;
      end
   end

   sync_fifo #(
      .WIDTH (128),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (fifo_wr),
      .wr_data ({in_payload, in_header}),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Beat sequencer; every output is a register and holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         out_data      <= '0;
         out_keep      <= 2'b00;
         out_sop       <= 1'b0;
         out_eop       <= 1'b0;
         out_valid     <= 1'b0;
         cpl_count     <= 16'h0000;
         hold_dw2      <= 32'h0;
         hold_payload  <= 32'h0;
         hold_has_data <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  out_data      <= hdr_fin[63:0];
                  out_keep      <= 2'b11;
                  out_sop       <= 1'b1;
                  out_eop       <= 1'b0;
                  out_valid     <= 1'b1;
                  hold_dw2      <= hdr_fin[95:64];
                  hold_payload  <= fifo_rd_data[127:96];
                  hold_has_data <= pop_has_data;
                  state         <= SEND0;
               end
            end
            SEND0: begin
               if (out_ready) begin
                  out_data <= {(hold_has_data ? hold_payload : 32'h0), hold_dw2};
                  out_keep <= hold_has_data ? 2'b11 : 2'b01;
                  out_sop  <= 1'b0;
                  out_eop  <= 1'b1;
                  state    <= SEND1;
               end
            end
            SEND1: begin
               if (out_ready) begin
                  cpl_count <= cpl_count + 16'd1;
                  if (!fifo_empty) begin
                     out_data      <= hdr_fin[63:0];
                     out_keep      <= 2'b11;
                     out_sop       <= 1'b1;
                     out_eop       <= 1'b0;
                     hold_dw2      <= hdr_fin[95:64];
                     hold_payload  <= fifo_rd_data[127:96];
                     hold_has_data <= pop_has_data;
                     state         <= SEND0;
                  end else begin
                     out_valid <= 1'b0;
                     out_eop   <= 1'b0;
                     state     <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpl_tlp_serializer.sv
// Scoreboard bench for cpl_tlp_serializer: a reference model queues expected beats on every accepted push.
module tb_cpl_tlp_serializer;

   localparam logic [15:0] CID = 16'h0100;

   logic         clk;
   logic         rst_n;
   logic [95:0]  in_header;
   logic [31:0]  in_payload;
   logic         in_valid;
   logic         in_ready;
   logic [63:0]  out_data;
   logic [1:0]   out_keep;
   logic         out_sop;
   logic         out_eop;
   logic         out_valid;
   logic         out_ready;
   logic [2:0]   fifo_level;
   logic [15:0]  cpl_count;
   logic [67:0]  cur_beat;

   int n_tests = 0;
   int n_fail  = 0;
   int beats_seen = 0;
   int eop_seen   = 0;
   logic [67:0] exp_q[$];

   cpl_tlp_serializer #(
      .DATA_WIDTH   (64),
      .FIFO_DEPTH   (4),
      .COMPLETER_ID (CID)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_header  (in_header),
      .in_payload (in_payload),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_keep   (out_keep),
      .out_sop    (out_sop),
      .out_eop    (out_eop),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .fifo_level (fifo_level),
      .cpl_count  (cpl_count)
   );

   assign cur_beat = {out_keep, out_sop, out_eop, out_data};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference beats as {keep, sop, eop, data}.
   function automatic logic [67:0] mdl_beat0(input logic [95:0] h);
      logic [31:0] dw1;
      dw1 = h[63:32];
      if (dw1[31:16] == 16'hFFFF) dw1[31:16] = CID;
      if (dw1[15:13] == 3'b111)   dw1[15:13] = 3'b000;
      return {2'b11, 1'b1, 1'b0, dw1, h[31:0]};
   endfunction

   function automatic logic [67:0] mdl_beat1(input logic [95:0] h, input logic [31:0] p);
      if (h[30]) return {2'b11, 1'b0, 1'b1, p, h[95:64]};
      return {2'b01, 1'b0, 1'b1, 32'h0, h[95:64]};
   endfunction

   function automatic logic [95:0] fill_hdr(input int k);
      logic [31:0] dw0;
      dw0 = (k % 2 == 1) ? 32'h0A00_0000 : 32'h4A00_0000;
      return {32'h0000_0300 + 32'(k), 32'hFFFF_E000 + 32'(k), dw0 + 32'(k)};
   endfunction

   // Scoreboard: push expectations on accepted input, compare on accepted output.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (in_valid && in_ready) begin
            exp_q.push_back(mdl_beat0(in_header));
            exp_q.push_back(mdl_beat1(in_header, in_payload));
         end
         if (out_valid && out_eop) eop_seen++;
         if (out_valid && out_ready) begin
            beats_seen++;
            if (exp_q.size() == 0)
               check("sb_extra_beat", 68'(exp_q.size()), 68'(1));
            else
               check("sb_beat", cur_beat, exp_q.pop_front());
         end
      end
   end

   task automatic push1(input logic [95:0] h, input logic [31:0] p);
      int w;
      w = 0;
      in_header  = h;
      in_payload = p;
      in_valid   = 1'b1;
      while (!in_ready && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      if (!in_ready) check("push_timeout", 68'(in_ready), 68'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int maxc);
      int w;
      w = 0;
      while ((out_valid || fifo_level != 0) && w < maxc) begin
         @(posedge clk); #1;
         w++;
      end
      if (out_valid || fifo_level != 0) check("idle_timeout", 68'(out_valid), 68'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int snap_eop;
      int snap_beats;
      logic [95:0] h3;
      logic [31:0] p3;

      rst_n      = 1'b1;
      in_valid   = 1'b0;
      in_header  = '0;
      in_payload = '0;
      out_ready  = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_out", {out_valid, out_sop, out_eop, out_keep, out_data}, 68'h0);
      check("rst_level", 68'(fifo_level), 68'(0));
      check("rst_count", 68'(cpl_count), 68'(0));
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", 68'(in_ready), 68'(1));

      // 1: data completion with ID and status substitution, plus latency
      out_ready = 1'b1;
      push1({32'h0000_1200, 32'hFFFF_E004, 32'h4A00_0001}, 32'hDEAD_BEEF);
      check("t1_lat_n", 68'(out_valid), 68'(0));
      @(posedge clk); #1;
      check("t1_lat_n1", 68'(out_valid), 68'(1));
      check("t1_beat0", cur_beat, {2'b11, 2'b10, 64'h0100_0004_4A00_0001});
      @(posedge clk); #1;
      check("t1_beat1", cur_beat, {2'b11, 2'b01, 64'hDEAD_BEEF_0000_1200});
      wait_idle(20);
      check("t1_count", 68'(cpl_count), 68'(1));

      // 2: no-data completion, UR status untouched
      push1({32'h0000_0700, 32'h1234_2003, 32'h0A00_0000}, 32'h5555_AAAA);
      @(posedge clk); #1;
      check("t2_beat0", cur_beat, {2'b11, 2'b10, 64'h1234_2003_0A00_0000});
      @(posedge clk); #1;
      check("t2_beat1", cur_beat, {2'b01, 2'b01, 64'h0000_0000_0000_0700});
      wait_idle(20);
      check("t2_count", 68'(cpl_count), 68'(2));

      // 3: backpressure during SEND0
      out_ready = 1'b0;
      h3 = {32'h0000_0042, 32'hABCD_E010, 32'h4A00_0002};
      p3 = 32'h0BAD_F00D;
      push1(h3, p3);
      @(posedge clk); #1;
      check("t3_hold0", cur_beat, mdl_beat0(h3));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("t3_hold", {out_valid, cur_beat[66:0]}, {1'b1, mdl_beat0(h3)});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("t3_beat1", cur_beat, mdl_beat1(h3, p3));
      wait_idle(20);
      check("t3_count", 68'(cpl_count), 68'(3));

      // 4: fill FIFO plus output stage, then drain without gaps
      out_ready = 1'b0;
      acc = 0;
      for (int k = 0; k < 8; k++) begin
         in_header  = fill_hdr(k);
         in_payload = 32'hC0DE_0000 + 32'(k);
         in_valid   = 1'b1;
         @(negedge clk);
         if (in_valid && in_ready) acc++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("t4_accepts", 68'(acc), 68'(5));
      check("t4_in_ready", 68'(in_ready), 68'(0));
      check("t4_level", 68'(fifo_level), 68'(4));
      out_ready = 1'b1;
      begin
         int run;
         bit done;
         run  = 0;
         done = 1'b0;
         for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (out_valid && !done) run++;
            else if (run > 0) done = 1'b1;
         end
         check("t4_run", 68'(run), 68'(10));
      end
      @(posedge clk); #1;
      wait_idle(20);
      check("t4_count", 68'(cpl_count), 68'(8));

      // 5: back-to-back TLPs
      fork
         begin
            for (int k = 0; k < 3; k++) begin
               in_header  = fill_hdr(k + 10);
               in_payload = 32'h7000_0000 + 32'(k);
               in_valid   = 1'b1;
               @(posedge clk); #1;
            end
            in_valid = 1'b0;
         end
         begin
            int run;
            bit done;
            run  = 0;
            done = 1'b0;
            for (int i = 0; i < 12; i++) begin
               @(negedge clk);
               if (out_valid && !done) run++;
               else if (run > 0) done = 1'b1;
            end
            check("t5_run", 68'(run), 68'(6));
         end
      join
      @(posedge clk); #1;
      wait_idle(20);
      check("t5_count", 68'(cpl_count), 68'(11));

      // 5b: counter wrap from 16'hFFFF
      force dut.cpl_count = 16'hFFFF;
      #1 release dut.cpl_count;
      @(posedge clk); #1;
      push1({32'h0000_0001, 32'h2222_0000, 32'h0A00_0000}, 32'h0);
      wait_idle(20);
      check("t5_wrap", 68'(cpl_count), 68'(0));
      check("sb_drained", 68'(exp_q.size()), 68'(0));

      // 6: reset while in SEND1 with two entries queued
      out_ready = 1'b0;
      push1(fill_hdr(20), 32'h1);
      push1(fill_hdr(21), 32'h2);
      push1(fill_hdr(22), 32'h3);
      check("t6_level", 68'(fifo_level), 68'(2));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("t6_in_send1", {66'h0, out_valid, out_eop}, 68'h3);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_valid", {66'h0, out_valid, out_eop}, 68'h0);
      snap_eop   = eop_seen;
      snap_beats = beats_seen;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("t6_level_after", 68'(fifo_level), 68'(0));
      check("t6_count_after", 68'(cpl_count), 68'(0));
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("t6_no_eop", 68'(eop_seen - snap_eop), 68'(0));
      check("t6_no_beats", 68'(beats_seen - snap_beats), 68'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
